// File: rtl/vco_spi_master_if.sv
// Register-write bus from serial_io into the ADF4350 SPI master.
// The host side drives the bus; the SPI master consumes it.
interface vco_spi_master_if;
    logic [6:0]  serial_addr;
    logic [31:0] serial_data;
    logic        serial_strobe;

    modport master (output serial_addr, output serial_data, output serial_strobe);
    modport slave  (input  serial_addr, input  serial_data, input  serial_strobe);
endinterface

// File: rtl/vco_spi_master.sv
// SPI master for the ADF4350: shifts queued 32-bit words MSB-first, then pulses LE.
// A one-word holding register lets the host issue back-to-back writes.
module vco_spi_master #(
    parameter logic [6:0]  DATA_ADDR = 7'd96,
    parameter logic [6:0]  CTRL_ADDR = 7'd97,
    parameter int unsigned CLKDIV    = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    vco_spi_master_if.slave        bus,
    input  logic                   muxout,
    output logic                   sclk,
    output logic                   sdata,
    output logic                   le,
    output logic                   busy,
    output logic [31:0]            status
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHIFT    = 3'd1,
        LE_SETUP = 3'd2,
        LE_PULSE = 3'd3,
        GAP      = 3'd4
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(CLKDIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  bit_q, bit_d;
    logic        sclk_q, sclk_d;
    logic [31:0] shift_q, shift_d;
    logic [31:0] hold_q, hold_d;
    logic        pending_q, pending_d;
    logic        overrun_q, overrun_d;
    logic        le_q, le_d;
    logic        busy_q, busy_d;
    logic        sync1_q, sync2_q;

    logic        wr_s, clr_s, cnt_done_s, gap_end_s, overrun_evt_s;

    assign wr_s       = bus.serial_strobe && (bus.serial_addr == DATA_ADDR);
    assign clr_s      = bus.serial_strobe && (bus.serial_addr == CTRL_ADDR) && bus.serial_data[0];
    assign cnt_done_s = (cnt_q == CNT_LAST);
    assign gap_end_s  = (state_q == GAP) && cnt_done_s;

    // Sequencer next-state: bit timing, LE framing and word hand-off.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_d         = bit_q;
        sclk_d        = sclk_q;
        shift_d       = shift_q;
        hold_d        = hold_q;
        pending_d     = pending_q;
        overrun_d     = overrun_q;
        le_d          = 1'b0;
        busy_d        = 1'b1;
        overrun_evt_s = 1'b0;

        case (state_q)
            IDLE: begin
                if (wr_s) begin
                    shift_d = bus.serial_data;
                    state_d = SHIFT;
                    cnt_d   = 8'd0;
                    bit_d   = 5'd0;
                    sclk_d  = 1'b0;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            SHIFT: begin
                if (!cnt_done_s) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    cnt_d = 8'd0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        // Falling edge: advance data; after bit 31 the register is all zeros.
                        sclk_d  = 1'b0;
                        shift_d = {shift_q[30:0], 1'b0};
                        if (bit_q == 5'd31) begin
                            state_d = LE_SETUP;
                            bit_d   = 5'd0;
                        end else begin
                            bit_d   = bit_q + 5'd1;
                        end
                    end
                end
            end
            LE_SETUP: begin
                if (cnt_done_s) begin
                    cnt_d   = 8'd0;
                    state_d = LE_PULSE;
                    le_d    = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            LE_PULSE: begin
                if (cnt_done_s) begin
                    cnt_d   = 8'd0;
                    state_d = GAP;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                    le_d    = 1'b1;
                end
            end
            GAP: begin
                if (cnt_done_s) begin
                    cnt_d  = 8'd0;
                    bit_d  = 5'd0;
                    sclk_d = 1'b0;
                    if (pending_q) begin
                        shift_d = hold_q;
                        state_d = SHIFT;
                    end else if (wr_s) begin
                        shift_d = bus.serial_data;
                        state_d = SHIFT;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Holding register: a word arriving as the held one is consumed simply replaces it.
        if (gap_end_s && pending_q) begin
            pending_d = wr_s;
            if (wr_s) begin
                hold_d = bus.serial_data;
            end else begin
                hold_d = hold_q;
            end
        end else if (wr_s && (state_q != IDLE) && !gap_end_s) begin
            if (!pending_q) begin
                hold_d    = bus.serial_data;
                pending_d = 1'b1;
            end else begin
                overrun_evt_s = 1'b1;
            end
        end else begin
            pending_d = pending_q;
        end

        if (clr_s) begin
            overrun_d = 1'b0;
        end else if (overrun_evt_s) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            bit_q     <= 5'd0;
            sclk_q    <= 1'b0;
            shift_q   <= 32'd0;
            hold_q    <= 32'd0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            le_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            sclk_q    <= sclk_d;
            shift_q   <= shift_d;
            hold_q    <= hold_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            le_q      <= le_d;
            busy_q    <= busy_d;
        end
    end

    // Two-flop synchroniser for the asynchronous MUXOUT lock detect.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= muxout;
            sync2_q <= sync1_q;
        end
    end

    assign sclk   = sclk_q;
    assign sdata  = shift_q[31];
    assign le     = le_q;
    assign busy   = busy_q;
    assign status = {28'd0, sync2_q, overrun_q, pending_q, busy_q};
endmodule

// File: tb/tb_vco_spi_master.sv
// Bench for vco_spi_master: expected words and LE/busy timing are queued at stimulus
// time; a monitor decodes the SPI pins and checks each LE-framed word against the queue.
module tb_vco_spi_master;
    localparam logic [6:0] DATA_ADDR = 7'd96;
    localparam logic [6:0] CTRL_ADDR = 7'd97;

    typedef struct {
        logic [31:0] word;
        int          le_cyc;
        int          busy_fall;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        muxout;
    logic        sclk_a, sdata_a, le_a, busy_a;
    logic        sclk_b, sdata_b, le_b, busy_b;
    logic [31:0] status_a, status_b;

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_viol  = 0;

    vco_spi_master_if bus_a();
    vco_spi_master_if bus_b();

    vco_spi_master #(.DATA_ADDR(DATA_ADDR), .CTRL_ADDR(CTRL_ADDR), .CLKDIV(4)) dut_a (
        .clock(clock), .reset_n(reset_n), .bus(bus_a), .muxout(muxout),
        .sclk(sclk_a), .sdata(sdata_a), .le(le_a), .busy(busy_a), .status(status_a)
    );

    vco_spi_master #(.DATA_ADDR(DATA_ADDR), .CTRL_ADDR(CTRL_ADDR), .CLKDIV(1)) dut_b (
        .clock(clock), .reset_n(reset_n), .bus(bus_b), .muxout(muxout),
        .sclk(sclk_b), .sdata(sdata_b), .le(le_b), .busy(busy_b), .status(status_b)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, required earlier finish", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic go_pos(input int c);
        while (cyc < c) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic go_neg(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    task automatic write(input int d, input logic [6:0] a, input logic [31:0] v, output int t);
        t = cyc;
        if (d == 0) begin
            bus_a.serial_addr   = a;
            bus_a.serial_data   = v;
            bus_a.serial_strobe = 1'b1;
        end else begin
            bus_b.serial_addr   = a;
            bus_b.serial_data   = v;
            bus_b.serial_strobe = 1'b1;
        end
        @(posedge clock);
        #1;
        bus_a.serial_strobe = 1'b0;
        bus_b.serial_strobe = 1'b0;
    endtask

    // Monitor: rebuild each word from sdata at sclk rises and score it when LE rises.
    initial begin : monitor
        logic        p_sclk [2];
        logic        p_le   [2];
        logic        p_busy [2];
        logic [31:0] cap    [2];
        int          nrise  [2];
        int          le_t0  [2];
        int          cur_bf [2];
        logic        s, q, l, b, have;
        int          dd;
        exp_t        e;
        for (int i = 0; i < 2; i++) begin
            p_sclk[i] = 1'b0; p_le[i] = 1'b0; p_busy[i] = 1'b0;
            cap[i] = 32'd0; nrise[i] = 0; le_t0[i] = 0; cur_bf[i] = -1;
        end
        forever begin
            @(negedge clock);
            for (int d = 0; d < 2; d++) begin
                s  = (d == 0) ? sclk_a  : sclk_b;
                q  = (d == 0) ? sdata_a : sdata_b;
                l  = (d == 0) ? le_a    : le_b;
                b  = (d == 0) ? busy_a  : busy_b;
                dd = (d == 0) ? 4 : 1;
                if (!reset_n) begin
                    p_sclk[d] = 1'b0; p_le[d] = 1'b0; p_busy[d] = 1'b0;
                    cap[d] = 32'd0; nrise[d] = 0; cur_bf[d] = -1;
                end else begin
                    if (l && s) n_viol++;
                    if (s && !b) n_viol++;
                    if (s && !p_sclk[d]) begin
                        cap[d]   = {cap[d][30:0], q};
                        nrise[d] = nrise[d] + 1;
                    end
                    if (l && !p_le[d]) begin
                        le_t0[d] = cyc;
                        have     = 1'b0;
                        if (d == 0 && exp_q0.size() > 0) begin
                            e = exp_q0.pop_front(); have = 1'b1;
                        end else if (d == 1 && exp_q1.size() > 0) begin
                            e = exp_q1.pop_front(); have = 1'b1;
                        end
                        if (!have) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL dut%0d_le_unexpected: le pulse at cycle %0d, required none", d, cyc);
                        end else begin
                            check($sformatf("dut%0d_word", d), cap[d], e.word);
                            check($sformatf("dut%0d_bit_count", d), 32'(nrise[d]), 32'd32);
                            check($sformatf("dut%0d_le_cycle", d), 32'(cyc), 32'(e.le_cyc));
                            cur_bf[d] = e.busy_fall;
                        end
                        cap[d]   = 32'd0;
                        nrise[d] = 0;
                    end
                    if (!l && p_le[d]) begin
                        check($sformatf("dut%0d_le_width", d), 32'(cyc - le_t0[d]), 32'(dd));
                    end
                    if (!b && p_busy[d]) begin
                        check($sformatf("dut%0d_busy_fall", d), 32'(cyc), 32'(cur_bf[d]));
                        cur_bf[d] = -1;
                    end
                    p_sclk[d] = s; p_le[d] = l; p_busy[d] = b;
                end
            end
        end
    end

    // Directed stimulus; word timing is relative to the accepting strobe cycle t.
    initial begin : stimulus
        int t, t1;
        reset_n = 1'b0;
        muxout  = 1'b0;
        bus_a.serial_addr = 7'd0; bus_a.serial_data = 32'd0; bus_a.serial_strobe = 1'b0;
        bus_b.serial_addr = 7'd0; bus_b.serial_data = 32'd0; bus_b.serial_strobe = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        check("reset_pins_a", 32'({sclk_a, sdata_a, le_a, busy_a}), 32'd0);
        check("reset_status_a", status_a, 32'd0);
        check("reset_status_b", status_b, 32'd0);

        // Single word, MSB and LSB set.
        write(0, DATA_ADDR, 32'h8000_0001, t);
        exp_q0.push_back('{32'h8000_0001, t + 261, t + 269});
        go_neg(t + 1);
        check("first_cycle_pins", 32'({sclk_a, sdata_a, busy_a}), 32'd3);
        go_neg(t + 268);
        check("busy_last_cycle", 32'(busy_a), 32'd1);
        go_pos(t + 280);

        // Strobe to an unrelated address is ignored.
        write(0, 7'd5, 32'hFFFF_FFFF, t);
        check("ignored_addr", status_a, 32'd0);
        go_pos(t + 20);

        // Back-to-back words through the holding register.
        write(0, DATA_ADDR, 32'h1234_5678, t);
        exp_q0.push_back('{32'h1234_5678, t + 261, -1});
        exp_q0.push_back('{32'h9ABC_DEF0, t + 529, t + 537});
        go_pos(t + 10);
        write(0, DATA_ADDR, 32'h9ABC_DEF0, t1);
        check("pending_set", 32'(status_a[2:0]), 32'd3);
        go_neg(t + 300);
        check("pending_consumed", 32'(status_a[2:0]), 32'd1);
        go_pos(t + 550);
        check("b2b_idle", 32'(status_a[2:0]), 32'd0);

        // Third write while a word is held is dropped and flags overrun.
        write(0, DATA_ADDR, 32'hC0FF_EE01, t);
        exp_q0.push_back('{32'hC0FF_EE01, t + 261, -1});
        exp_q0.push_back('{32'h5555_AAAA, t + 529, t + 537});
        go_pos(t + 5);
        write(0, DATA_ADDR, 32'h5555_AAAA, t1);
        write(0, DATA_ADDR, 32'hDEAD_BEEF, t1);
        check("overrun_set", 32'(status_a[2:1]), 32'd3);
        go_pos(t + 550);
        check("overrun_sticky", 32'(status_a[2:0]), 32'd4);
        write(0, CTRL_ADDR, 32'd1, t);
        check("overrun_clear", 32'(status_a[2:0]), 32'd0);
        go_pos(t + 5);

        // Lock detect through the synchroniser while a word is in flight.
        write(0, DATA_ADDR, 32'h0F1E_2D3C, t);
        exp_q0.push_back('{32'h0F1E_2D3C, t + 261, t + 269});
        go_pos(t + 100);
        muxout = 1'b1;
        go_neg(t + 101);
        check("lock_latency", 32'(status_a[3]), 32'd0);
        go_neg(t + 102);
        check("lock_status", 32'(status_a[3:0]), 32'd9);
        go_pos(t + 280);

        // Reset mid-word: the word is lost and no LE appears afterwards.
        write(0, DATA_ADDR, 32'hA5A5_A5A5, t);
        go_pos(t + 150);
        reset_n = 1'b0;
        #1;
        check("midword_reset_pins", 32'({sclk_a, sdata_a, le_a, busy_a}), 32'd0);
        check("midword_reset_status", status_a, 32'd0);
        muxout = 1'b0;
        go_pos(t + 153);
        reset_n = 1'b1;
        go_pos(t + 453);
        write(0, DATA_ADDR, 32'h3C3C_00FF, t);
        exp_q0.push_back('{32'h3C3C_00FF, t + 261, t + 269});
        go_pos(t + 280);

        // CLKDIV=1 instance: sclk toggles every cycle, one-cycle LE.
        write(1, DATA_ADDR, 32'hFFFF_FFFF, t);
        exp_q1.push_back('{32'hFFFF_FFFF, t + 66, t + 68});
        go_neg(t + 1);
        check("div1_cycle1", 32'({sclk_b, sdata_b, busy_b}), 32'd3);
        go_neg(t + 2);
        check("div1_cycle2", 32'({sclk_b, sdata_b, busy_b}), 32'd7);
        go_pos(t + 80);

        check("words_outstanding_a", 32'(exp_q0.size()), 32'd0);
        check("words_outstanding_b", 32'(exp_q1.size()), 32'd0);
        check("protocol_violations", 32'(n_viol), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
